rgb_sbit2wrd_p: RTL and testbench
=================================

# rgb_sbit2wrd_p

Parametrised serial-bit-to-word assembler for WS2812b-style input streams. It sits between the serial bit detector (`rgb_sinp`) and the word FIFO. It collects strobed bits MSB-first into DATA_BITS-wide pixels: 24 for G-R-B, 32 for G-R-B-W. Each pixel is emitted with a status byte through a small holding queue that absorbs short FIFO-full periods. Overflows are counted, and the block resynchronises on the next stream reset.

## Interface
- DATA_BITS, 24, pixel width in bits, 8..32, multiple of 8.
- HOLD_DEPTH, 2, holding-queue entries, 1..8.
- CNT_WIDTH, 8, overflow-counter width.
- EMIT_RESET_MARKER, 1, 1 = every stream reset emits a word; 0 = only a reset that cuts a partial pixel, or that ends a resync, emits a word.
- clk  in  1  system clock, 96 MHz.
- rst_n  in  1  reset, asynchronous, active-low.
- in_strobe  in  1  high for ≥2 clocks per event; only the rising edge is an event.
- in_sbit_value  in  1  bit value, meaningful when in_stream_reset=0.
- in_stream_reset  in  1  1 = 50 µs stable line (frame boundary).
- in_wr_fifo_full  in  1  1 = downstream FIFO cannot accept a write this cycle.
- in_clr_status  in  1  synchronous clear of the overflow flag and counter.
- out_word  out  DATA_BITS+8  {status[7:0], data[DATA_BITS-1:0]}.
- out_strobe  out  1  one-clock write strobe for out_word.
- out_wr_fifo_overflow  out  1  sticky: set when a word was dropped.
- out_ovf_count  out  CNT_WIDTH  count of dropped words, saturating at all-ones.
- out_resync_wait  out  1  1 = discarding input until a stream reset.

## Operation
- Status byte bit fields:
  - bit7 valid.
  - bit6 stream_reset.
  - bit5 partial (a stream reset arrived mid-pixel).
  - bit4 resync (first word after an overflow).
  - bits3-0 zero.
- Event: a registered copy of in_strobe is 0 and the current in_strobe is 1. in_sbit_value and in_stream_reset are sampled at that same edge.
- Bit event: data[bcount] <= value.
  - bcount counts down from DATA_BITS-1.
  - When bcount reaches 0, push {8'h80, data} and reload bcount to DATA_BITS-1.
- Stream-reset event:
  - bcount ≠ DATA_BITS-1: push {8'hE0, data}. Bits not yet received are 0.
  - bcount = DATA_BITS-1 and EMIT_RESET_MARKER=1: push {8'hC0, 0}.
  - In both cases, clear the data register and reload bcount.
- Overflow: a push is attempted while the queue is full and no pop occurs in the same cycle.
  - The word is dropped.
  - out_wr_fifo_overflow is set.
  - out_ovf_count increments, saturating.
  - out_resync_wait is set.
- While out_resync_wait=1:
  - Bit events do not push; bits are discarded.
  - The next stream-reset event clears the wait and pushes {8'hD0, 0}, whether or not EMIT_RESET_MARKER is set and whatever the partial state.
- Queue: circular buffer of HOLD_DEPTH entries with a count register.
  - Pop when the queue is non-empty and in_wr_fifo_full=0: out_word <= head, out_strobe <= 1.
  - Strobes may be back-to-back.
  - Push and pop in the same cycle are both allowed, including when the queue is full.
- out_word holds the last popped value between strobes.
- in_clr_status clears the flag and counter. It does not clear out_resync_wait. If it coincides with an overflow, the overflow wins: the flag becomes 1 and the count becomes 1.

## Timing
- Reset (rst_n=0, asynchronous):
  - out_word=0, out_strobe=0, out_wr_fifo_overflow=0, out_ovf_count=0, out_resync_wait=0.
  - Queue empty, bcount=DATA_BITS-1, data register and edge register 0.
  - Reset deassertion is synchronised internally with a 2-flop release. Events are ignored until release completes.
- Event detected at edge E: the push occurs at E. With the queue empty and the FIFO not full, out_strobe is high in the cycle after E+1. Latency is 2 clocks from the first sampled-high in_strobe.
- An in_strobe held high produces exactly one event. The line must be low for ≥1 sampled edge before the next event.
- in_wr_fifo_full is evaluated at the same edge as the pop decision. A single full cycle delays the pop by one cycle.
- Reset mid-pixel discards the partial pixel and the queue contents. No strobe is issued.

## Test plan
- DATA_BITS=24: 24 bit events, values 0xA5C3F0 MSB-first, FIFO never full -> one strobe, out_word=0x80A5C3F0, 2 clocks after the 24th event.
- DATA_BITS=32, EMIT_RESET_MARKER=1: 32 bits 0x12345678, then a stream reset -> strobes 0x8012345678 then 0xC000000000.
- 8 bits 0xFF, then a stream reset -> out_word = 0xE0FF0000 (partial) and bcount reloaded; the next 24 bits assemble normally.
- HOLD_DEPTH=2, in_wr_fifo_full held high across 3 completed pixels:
  - Response: out_wr_fifo_overflow=1, out_ovf_count=1, out_resync_wait=1.
  - Later pixels are dropped silently until a stream reset.
  - After full drops, exactly 2 queued words drain, then 0xD0000000 follows the reset.
- Queue full, with push and pop in the same cycle -> no overflow and no count change.
- Assert rst_n low at mid-pixel bit 10 while the queue holds 1 word -> all outputs 0 immediately; after release, a fresh 24-bit pixel yields a correct word and nothing stale is emitted.

Source files
------------

// File: rtl/rgb_sbit2wrd_p.sv
// Serial-bit to pixel-word assembler for WS2812b-style streams: collects strobed bits
// MSB-first, tags each word with a status byte and buffers it in a small holding queue.
module rgb_sbit2wrd_p #(
    parameter int unsigned DATA_BITS         = 24,
    parameter int unsigned HOLD_DEPTH        = 2,
    parameter int unsigned CNT_WIDTH         = 8,
    parameter bit          EMIT_RESET_MARKER = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_strobe,
    input  logic                   in_sbit_value,
    input  logic                   in_stream_reset,
    input  logic                   in_wr_fifo_full,
    input  logic                   in_clr_status,
    output logic [DATA_BITS+7:0]   out_word,
    output logic                   out_strobe,
    output logic                   out_wr_fifo_overflow,
    output logic [CNT_WIDTH-1:0]   out_ovf_count,
    output logic                   out_resync_wait
);

    localparam int unsigned WORD_W = DATA_BITS + 8;
    localparam int unsigned BC_W   = $clog2(DATA_BITS);
    localparam int unsigned PTR_W  = (HOLD_DEPTH > 1) ? $clog2(HOLD_DEPTH) : 1;
    localparam int unsigned QCNT_W = $clog2(HOLD_DEPTH + 1);

    localparam logic [BC_W-1:0]      BC_TOP   = BC_W'(DATA_BITS - 1);
    localparam logic [QCNT_W-1:0]    Q_FULL   = QCNT_W'(HOLD_DEPTH);
    localparam logic [PTR_W-1:0]     PTR_LAST = PTR_W'(HOLD_DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    localparam logic [7:0] ST_PIXEL   = 8'h80;
    localparam logic [7:0] ST_MARKER  = 8'hC0;
    localparam logic [7:0] ST_PARTIAL = 8'hE0;
    localparam logic [7:0] ST_RESYNC  = 8'hD0;

    logic [1:0]              r_rst_sync;
    logic                    r_strobe_d;
    logic [DATA_BITS-1:0]    r_data;
    logic [BC_W-1:0]         r_bcount;
    logic [WORD_W-1:0]       r_q [HOLD_DEPTH];
    logic [PTR_W-1:0]        r_wptr;
    logic [PTR_W-1:0]        r_rptr;
    logic [QCNT_W-1:0]       r_qcount;

    logic                    w_run;
    logic                    w_event;
    logic                    w_bit_evt;
    logic                    w_sr_evt;
    logic [DATA_BITS-1:0]    w_data_ins;
    logic                    w_push;
    logic [WORD_W-1:0]       w_push_word;
    logic                    w_pop;
    logic                    w_ovf;
    logic                    w_wr;

    // Reset release is delayed two clocks; events are ignored until it completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rst_sync <= '0;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    assign w_run     = r_rst_sync[1];
    assign w_event   = w_run && in_strobe && !r_strobe_d;
    assign w_bit_evt = w_event && !in_stream_reset;
    assign w_sr_evt  = w_event && in_stream_reset;

    always_comb begin
        w_data_ins           = r_data;
        w_data_ins[r_bcount] = in_sbit_value;
    end

    always_comb begin
        w_push      = 1'b0;
        w_push_word = '0;
        if (w_bit_evt && !r_resync_wait_q() && r_bcount == '0) begin
            w_push      = 1'b1;
            w_push_word = {ST_PIXEL, w_data_ins};
        end
        if (w_sr_evt) begin
            if (out_resync_wait) begin
                w_push      = 1'b1;
                w_push_word = {ST_RESYNC, {DATA_BITS{1'b0}}};
            end else if (r_bcount != BC_TOP) begin
                w_push      = 1'b1;
                w_push_word = {ST_PARTIAL, r_data};
            end else if (EMIT_RESET_MARKER) begin
                w_push      = 1'b1;
                w_push_word = {ST_MARKER, {DATA_BITS{1'b0}}};
            end
        end
    end

    function automatic logic r_resync_wait_q();
        return out_resync_wait;
    endfunction

    assign w_pop = (r_qcount != '0) && !in_wr_fifo_full;
    assign w_ovf = w_push && (r_qcount == Q_FULL) && !w_pop;
    assign w_wr  = w_push && !w_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_strobe_d <= 1'b0;
            r_data     <= '0;
            r_bcount   <= BC_TOP;
        end else begin
            r_strobe_d <= in_strobe;
            if (w_bit_evt && !out_resync_wait) begin
                // Clearing on completion keeps unreceived bits of a later partial pixel at 0.
                if (r_bcount == '0) begin
                    r_data   <= '0;
                    r_bcount <= BC_TOP;
                end else begin
                    r_data   <= w_data_ins;
                    r_bcount <= r_bcount - 1'b1;
                end
            end else if (w_sr_evt) begin
                r_data   <= '0;
                r_bcount <= BC_TOP;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_wr_fifo_overflow <= 1'b0;
            out_ovf_count        <= '0;
            out_resync_wait      <= 1'b0;
        end else begin
            if (w_ovf) begin
                out_wr_fifo_overflow <= 1'b1;
                if (in_clr_status)
                    out_ovf_count <= CNT_WIDTH'(1);
                else if (out_ovf_count != CNT_MAX)
                    out_ovf_count <= out_ovf_count + 1'b1;
            end else if (in_clr_status) begin
                out_wr_fifo_overflow <= 1'b0;
                out_ovf_count        <= '0;
            end

            if (w_ovf)
                out_resync_wait <= 1'b1;
            else if (w_sr_evt && out_resync_wait)
                out_resync_wait <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_q[r_wptr] <= w_push_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_qcount   <= '0;
            out_word   <= '0;
            out_strobe <= 1'b0;
        end else begin
            out_strobe <= w_pop;
            if (w_pop) begin
                out_word <= r_q[r_rptr];
                r_rptr   <= (r_rptr == PTR_LAST) ? '0 : r_rptr + 1'b1;
            end
            if (w_wr)
                r_wptr <= (r_wptr == PTR_LAST) ? '0 : r_wptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_qcount <= r_qcount + 1'b1;
                2'b01:   r_qcount <= r_qcount - 1'b1;
                default: r_qcount <= r_qcount;
            endcase
        end
    end

endmodule

// File: tb/tb_rgb_sbit2wrd_p.sv
// Directed bench for rgb_sbit2wrd_p: a 24-bit/2-deep instance and a 32-bit instance,
// both emitting reset markers, checked against hand-computed words.
module tb_rgb_sbit2wrd_p;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  strb, val, srst, full, clr;
    logic [31:0] ow0;
    logic [39:0] ow1;
    logic [1:0]  ostb, ovf, rsw;
    logic [7:0]  oc0, oc1;

    always #5 clk = ~clk;

    rgb_sbit2wrd_p #(.DATA_BITS(24), .HOLD_DEPTH(2), .CNT_WIDTH(8), .EMIT_RESET_MARKER(1'b1)) u_dut24 (
        .clk(clk), .rst_n(rst_n), .in_strobe(strb[0]), .in_sbit_value(val[0]),
        .in_stream_reset(srst[0]), .in_wr_fifo_full(full[0]), .in_clr_status(clr[0]),
        .out_word(ow0), .out_strobe(ostb[0]), .out_wr_fifo_overflow(ovf[0]),
        .out_ovf_count(oc0), .out_resync_wait(rsw[0]));

    rgb_sbit2wrd_p #(.DATA_BITS(32), .HOLD_DEPTH(2), .CNT_WIDTH(8), .EMIT_RESET_MARKER(1'b1)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_strobe(strb[1]), .in_sbit_value(val[1]),
        .in_stream_reset(srst[1]), .in_wr_fifo_full(full[1]), .in_clr_status(clr[1]),
        .out_word(ow1), .out_strobe(ostb[1]), .out_wr_fifo_overflow(ovf[1]),
        .out_ovf_count(oc1), .out_resync_wait(rsw[1]));

    int          cyc = 0;
    int          t_last = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [39:0] cap0[$];
    logic [39:0] cap1[$];
    int          capc0[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ostb[0] === 1'b1) begin
            cap0.push_back({8'h00, ow0});
            capc0.push_back(cyc);
        end
        if (ostb[1] === 1'b1) cap1.push_back(ow1);
    end

    task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic send_evt(input int d, input logic v, input logic sr);
        @(negedge clk);
        strb[d] = 1'b1; val[d] = v; srst[d] = sr; t_last = cyc;
        @(negedge clk);
        @(negedge clk);
        strb[d] = 1'b0; val[d] = 1'b0; srst[d] = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_px(input int d, input logic [31:0] px, input int nb);
        for (int i = nb - 1; i >= 0; i--) send_evt(d, px[i], 1'b0);
    endtask

    task automatic expect_word(input int d, input string tag, input logic [39:0] exp, output int at);
        logic [39:0] got;
        int t;
        got = 'x;
        at  = -1;
        t   = 0;
        while (((d == 0) ? cap0.size() : cap1.size()) == 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (d == 0 && cap0.size() > 0) begin
            got = cap0.pop_front();
            at  = capc0.pop_front();
        end else if (d == 1 && cap1.size() > 0) begin
            got = cap1.pop_front();
        end
        check(tag, got, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int at;
        logic [31:0] px;
        strb = '0; val = '0; srst = '0; full = '0; clr = '0;
        #2 rst_n = 1'b0;
        #20;
        check("rst_word24", 40'(ow0), 40'h0);
        check("rst_word32", ow1, 40'h0);
        check("rst_strobe", 40'(ostb), 40'h0);
        check("rst_ovf", 40'(ovf), 40'h0);
        check("rst_cnt24", 40'(oc0), 40'h0);
        check("rst_cnt32", 40'(oc1), 40'h0);
        check("rst_resync", 40'(rsw), 40'h0);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Plain 24-bit pixel and its latency from the last strobe.
        send_px(0, 32'h00A5C3F0, 24);
        expect_word(0, "pix_a5c3f0", 40'h80A5C3F0, at);
        check("latency", 40'(at - t_last), 40'd2);
        repeat (4) @(negedge clk);
        check("single_strobe", 40'(cap0.size()), 40'd0);

        // Partial pixel cut by a stream reset, then a normal pixel.
        send_px(0, 32'h000000FF, 8);
        send_evt(0, 1'b0, 1'b1);
        expect_word(0, "partial", 40'hE0FF0000, at);
        send_px(0, 32'h00123456, 24);
        expect_word(0, "after_partial", 40'h80123456, at);

        // 32-bit pixel followed by a reset on a pixel boundary.
        send_px(1, 32'h12345678, 32);
        send_evt(1, 1'b0, 1'b1);
        expect_word(1, "pix32", 40'h8012345678, at);
        expect_word(1, "marker32", 40'hC000000000, at);

        // Overflow while the FIFO is full, then resync.
        @(negedge clk) full[0] = 1'b1;
        send_px(0, 32'h000F0F0F, 24);
        send_px(0, 32'h00F0F0F0, 24);
        send_px(0, 32'h00ABCDEF, 24);
        check("ovf_flag", 40'(ovf[0]), 40'd1);
        check("ovf_count", 40'(oc0), 40'd1);
        check("ovf_resync", 40'(rsw[0]), 40'd1);
        check("held_while_full", 40'(cap0.size()), 40'd0);
        send_px(0, 32'h00010203, 24);
        check("silent_drop_cnt", 40'(oc0), 40'd1);
        @(negedge clk) clr[0] = 1'b1;
        @(negedge clk) clr[0] = 1'b0;
        @(negedge clk);
        check("clr_flag", 40'(ovf[0]), 40'd0);
        check("clr_count", 40'(oc0), 40'd0);
        check("clr_keeps_resync", 40'(rsw[0]), 40'd1);
        full[0] = 1'b0;
        expect_word(0, "drain1", 40'h800F0F0F, at);
        expect_word(0, "drain2", 40'h80F0F0F0, at);
        repeat (5) @(negedge clk);
        check("drain_only_two", 40'(cap0.size()), 40'd0);
        send_evt(0, 1'b0, 1'b1);
        expect_word(0, "resync_word", 40'hD0000000, at);
        check("resync_cleared", 40'(rsw[0]), 40'd0);

        // Full queue with push and pop in the same cycle.
        @(negedge clk) full[0] = 1'b1;
        send_px(0, 32'h00111111, 24);
        send_px(0, 32'h00222222, 24);
        px = 32'h00333333;
        for (int i = 23; i >= 1; i--) send_evt(0, px[i], 1'b0);
        @(negedge clk);
        strb[0] = 1'b1; val[0] = px[0]; full[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        strb[0] = 1'b0; val[0] = 1'b0;
        @(negedge clk);
        expect_word(0, "pp_word1", 40'h80111111, at);
        expect_word(0, "pp_word2", 40'h80222222, at);
        expect_word(0, "pp_word3", 40'h80333333, at);
        check("pp_no_ovf", 40'(ovf[0]), 40'd0);
        check("pp_no_count", 40'(oc0), 40'd0);

        // Asynchronous reset mid-pixel with one word queued.
        @(negedge clk) full[0] = 1'b1;
        send_px(0, 32'h00444444, 24);
        px = 32'h00777777;
        for (int i = 23; i >= 14; i--) send_evt(0, px[i], 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_word24", 40'(ow0), 40'h0);
        check("arst_word32", ow1, 40'h0);
        check("arst_strobe", 40'(ostb), 40'h0);
        check("arst_ovf", 40'(ovf), 40'h0);
        check("arst_resync", 40'(rsw), 40'h0);
        full[0] = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("no_stale", 40'(cap0.size()), 40'd0);
        send_px(0, 32'h005A5A5A, 24);
        expect_word(0, "post_reset_pix", 40'h805A5A5A, at);
        repeat (5) @(negedge clk);
        check("post_reset_single", 40'(cap0.size()), 40'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
